// File: rtl/mont_io_buffer.sv
// Streams A, B, M into wide operand registers, kicks the Montgomery multiplier, then streams the result out LS word first.
// Start pulse 1 cycle after the last input beat; m_valid 1 cycle after mont_done; m_ready low freezes m_data and the word index.
module mont_io_buffer #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OP_W-1:0]   mont_a,
  output logic [OP_W-1:0]   mont_b,
  output logic [OP_W-1:0]   mont_m,
  output logic              mont_start,
  input  logic [OP_W-1:0]   mont_result,
  input  logic              mont_done,
  output logic              busy
);

  localparam int NW    = OP_W / DATA_W;
  localparam int IN_W  = $clog2(3 * NW);
  localparam int OUT_W = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(3 * NW - 1);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(NW - 1);

  typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} state_t;

  state_t            state, stateNext;
  logic [IN_W-1:0]   inCnt;
  logic [OUT_W-1:0]  outCnt;
  logic [OP_W-1:0]   opA, opB, opM, resReg;
  logic              inBeat, outBeat;

  assign inBeat  = s_valid && s_ready;
  assign outBeat = m_valid && m_ready;
  assign mont_a  = opA;
  assign mont_b  = opB;
  assign mont_m  = opM;

  always_comb begin
    stateNext  = state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    mont_start = 1'b0;
    busy       = 1'b1;
    case (state)
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (s_valid && inCnt == IN_LAST) stateNext = START;
      end
      START: begin
        mont_start = 1'b1;
        stateNext  = WAIT;
      end
      WAIT: begin
        if (mont_done) stateNext = UNLOAD;
      end
      UNLOAD: begin
        m_valid = 1'b1;
        if (m_ready && outCnt == OUT_LAST) stateNext = LOAD;
      end
      default: stateNext = LOAD;
    endcase
  end

  always_comb begin
    m_data = '0;
    for (int i = 0; i < NW; i++) begin
      if (outCnt == OUT_W'(i)) m_data = resReg[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= LOAD;
      inCnt  <= '0;
      outCnt <= '0;
      opA    <= '0;
      opB    <= '0;
      opM    <= '0;
      resReg <= '0;
    end else begin
      state <= stateNext;
      // Slot k lands in A, B or M depending on which third of the stream it falls in.
      if (inBeat) begin
        inCnt <= (inCnt == IN_LAST) ? '0 : inCnt + 1'b1;
        for (int i = 0; i < NW; i++) begin
          if (inCnt == IN_W'(i))          opA[i*DATA_W +: DATA_W] <= s_data;
          if (inCnt == IN_W'(NW + i))     opB[i*DATA_W +: DATA_W] <= s_data;
          if (inCnt == IN_W'(2 * NW + i)) opM[i*DATA_W +: DATA_W] <= s_data;
        end
      end
      if (state == WAIT && mont_done) resReg <= mont_result;
      if (outBeat) outCnt <= (outCnt == OUT_LAST) ? '0 : outCnt + 1'b1;
    end
  end

endmodule

// File: doc/mont_io_buffer.md
MONT_IO_BUFFER -- requirements
Module: mont_io_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, stream word width in bits.
REQ-002 SHALL have parameter OP_W, default 512, operand width in bits; OP_W SHALL be an integer multiple of DATA_W; NW = OP_W/DATA_W (16 at defaults).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port s_data  input  DATA_W  inbound operand word.
REQ-006 SHALL have port s_valid  input  1  s_data valid.
REQ-007 SHALL have port s_ready  output  1  block accepts s_data.
REQ-008 SHALL have port m_data  output  DATA_W  outbound result word.
REQ-009 SHALL have port m_valid  output  1  m_data valid.
REQ-010 SHALL have port m_ready  input  1  consumer accepts m_data.
REQ-011 SHALL have port mont_a, mont_b, mont_m  output  OP_W each  operands driven to the multiplier's in_a/in_b/in_m.
REQ-012 SHALL have port mont_start  output  1  one-cycle start pulse to the multiplier.
REQ-013 SHALL have port mont_result  input  OP_W  multiplier result.
REQ-014 SHALL have port mont_done  input  1  multiplier completion flag.
REQ-015 SHALL have port busy  output  1  high in every state except LOAD.

Function
REQ-016 SHALL implement FSM states LOAD, START, WAIT, UNLOAD; reset state LOAD.
REQ-017 LOAD: s_ready=1; each beat (s_valid&s_ready) SHALL store s_data into word slot k of a 3*NW-word counter, k=0..3*NW-1.
REQ-018 Word order SHALL be: A words 0..NW-1, then B, then M; least-significant word first within each operand.
REQ-019 Beats with s_valid=0 SHALL change nothing; s_ready SHALL be 0 outside LOAD.
REQ-020 On the beat storing k=3*NW-1 the FSM SHALL go to START next cycle and clear the counter.
REQ-021 START: mont_start=1 for exactly one cycle, then WAIT unconditionally.
REQ-022 mont_a/mont_b/mont_m SHALL be registered and SHALL NOT change from START entry until UNLOAD exit.
REQ-023 WAIT: first cycle with mont_done=1 SHALL capture mont_result into the result register and move to UNLOAD next cycle.
REQ-024 mont_done SHALL be ignored in LOAD, START and UNLOAD.
REQ-025 UNLOAD: m_valid=1, m_data = result word j (LS first, j=0..NW-1); j SHALL advance only on m_valid&m_ready.
REQ-026 Under backpressure (m_ready=0) m_data and j SHALL stay constant.
REQ-027 On acceptance of j=NW-1 the FSM SHALL return to LOAD next cycle with both counters at 0; m_valid drops that same next cycle.
REQ-028 Latency: last input beat at edge T -> mont_start high in cycle T+1; mont_done seen in cycle D -> m_valid high in cycle D+1.
REQ-029 Counters SHALL be sized for 3*NW and NW and SHALL never wrap beyond their terminal value.

Reset
REQ-030 Reset asserted at any edge, including mid-LOAD, WAIT or UNLOAD, SHALL next cycle give state LOAD, counters 0, operand and result registers 0.
REQ-031 After reset: s_ready=1, m_valid=0, mont_start=0, busy=0, m_data=0, mont_a/b/m=0.
REQ-032 Reset SHALL have priority over any simultaneous handshake or mont_done.

Verification
REQ-033 Basic: load A=3, B=5, M=7 (48 beats, upper words 0); stub multiplier asserts mont_done 10 cycles after start with result 0x1 -> one mont_start pulse, outputs m_data 0x00000001 then 15 zero words.
REQ-034 Word order: A words = 0x100+i, B = 0x200+i, M = 0x300+i -> mont_a[31:0]=0x100, mont_a[511:480]=0x10F, mont_m[511:480]=0x30F at start.
REQ-035 Gaps and backpressure: random s_valid gaps and m_ready low 3 cycles per word -> no lost/duplicated words; m_data stable while m_ready=0.
REQ-036 Spurious done: mont_done pulsed during LOAD -> ignored, no UNLOAD; s_ready stays 1.
REQ-037 Reset in WAIT and in UNLOAD word 5 -> next cycle state LOAD, s_ready=1, m_valid=0; next full transaction completes correctly.
REQ-038 Back-to-back: two transactions with m_ready tied 1 -> second LOAD begins the cycle after the 16th result word is accepted.
